cpu_state_sequencer: RTL and testbench



---
 rtl/cpu_state_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_state_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_sequencer.sv
// Multicycle state sequencer for the MIPS core: HALT/FETCH/DECODE/EXECk sequencing
// with per-instruction exec length, memory and mul/div stalls, halt detection and counters.
module cpu_state_sequencer #(
    parameter int unsigned EXEC_STAGES = 2,
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waitrequest,
    input  logic               mem_access,
    input  logic [3:0]         exec_len,
    input  logic               div_mult_busy,
    input  logic               div_mult_wait,
    input  logic               halt_req,
    output logic [STATE_W-1:0] state,
    output logic               active,
    output logic               last_exec,
    output logic               stall,
    output logic               commit,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   stall_count
);

    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        PH_HALT   = 2'd0,
        PH_FETCH  = 2'd1,
        PH_DECODE = 2'd2,
        PH_EXEC   = 2'd3
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [LEN_W-1:0]   len_clamp;

    // Exec length of 0 still needs one exec state; anything above the pipeline depth saturates.
    always_comb begin
        len_clamp = exec_len;
        if (exec_len == LEN_W'(0)) begin
            len_clamp = LEN_W'(1);
        end else if (32'(exec_len) > 32'(EXEC_STAGES)) begin
            len_clamp = LEN_W'(EXEC_STAGES);
        end
    end

    assign active    = (phase_q != PH_HALT);
    assign last_exec = (phase_q == PH_EXEC) && (k_q == len_q);
    assign stall     = active && ((mem_access && waitrequest) ||
                                  (last_exec && div_mult_wait && div_mult_busy));
    assign commit    = last_exec && !stall;

    always_comb begin
        state = STATE_W'(0);
        case (phase_q)
            PH_HALT:   state = STATE_W'(0);
            PH_FETCH:  state = STATE_W'(1);
            PH_DECODE: state = STATE_W'(2);
            PH_EXEC:   state = STATE_W'(2) + STATE_W'(k_q);
        endcase
    end

    assign instr_count = instr_q;
    assign stall_count = stall_cnt_q;

    // Next-state: everything holds while stalled; HALT only leaves through reset.
    always_comb begin
        phase_d     = phase_q;
        k_d         = k_q;
        len_d       = len_q;
        instr_d     = instr_q + CNT_W'(commit);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
        if (!stall) begin
            case (phase_q)
                PH_HALT:   phase_d = PH_HALT;
                PH_FETCH:  phase_d = PH_DECODE;
                PH_DECODE: begin
                    phase_d = PH_EXEC;
                    k_d     = LEN_W'(1);
                    len_d   = len_clamp;
                end
                PH_EXEC: begin
                    if (last_exec) begin
                        phase_d = halt_req ? PH_HALT : PH_FETCH;
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= PH_FETCH;
            k_q         <= LEN_W'(1);
            len_q       <= LEN_W'(1);
            instr_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            k_q         <= k_d;
            len_q       <= len_d;
            instr_q     <= instr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed self-checking bench for cpu_state_sequencer (EXEC_STAGES=5).
module tb_cpu_state_sequencer;

    localparam int unsigned EXEC_STAGES = 5;
    localparam int unsigned STATE_W     = 4;
    localparam int unsigned CNT_W       = 32;

    logic               clk;
    logic               reset;
    logic               waitrequest;
    logic               mem_access;
    logic [3:0]         exec_len;
    logic               div_mult_busy;
    logic               div_mult_wait;
    logic               halt_req;
    logic [STATE_W-1:0] state;
    logic               active;
    logic               last_exec;
    logic               stall;
    logic               commit;
    logic [CNT_W-1:0]   instr_count;
    logic [CNT_W-1:0]   stall_count;

    int errors = 0;
    int checks = 0;

    cpu_state_sequencer #(
        .EXEC_STAGES(EXEC_STAGES),
        .STATE_W    (STATE_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .waitrequest  (waitrequest),
        .mem_access   (mem_access),
        .exec_len     (exec_len),
        .div_mult_busy(div_mult_busy),
        .div_mult_wait(div_mult_wait),
        .halt_req     (halt_req),
        .state        (state),
        .active       (active),
        .last_exec    (last_exec),
        .stall        (stall),
        .commit       (commit),
        .instr_count  (instr_count),
        .stall_count  (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        waitrequest   = 1'b0;
        mem_access    = 1'b0;
        exec_len      = 4'd2;
        div_mult_busy = 1'b0;
        div_mult_wait = 1'b0;
        halt_req      = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_state", 32'(state), 32'd1);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_last_exec", 32'(last_exec), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_instr", instr_count, 32'd0);
        chk("rst_stallcnt", stall_count, 32'd0);
        reset = 1'b0;

        // Unstalled len=2 loop: 1,2,3,4,1,...
        for (int i = 1; i < 12; i++) begin
            @(negedge clk); #1;
            chk("seq_state", 32'(state), 32'((i % 4) + 1));
            chk("seq_commit", 32'(commit), (i % 4 == 3) ? 32'd1 : 32'd0);
        end

        // FETCH held 3 cycles by waitrequest
        @(negedge clk); mem_access = 1'b1; waitrequest = 1'b1; #1;
        chk("loop_instr", instr_count, 32'd3);
        chk("fstall_state", 32'(state), 32'd1);
        chk("fstall_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("fstall_state", 32'(state), 32'd1);
            chk("fstall_stall", 32'(stall), 32'd1);
        end
        @(negedge clk); waitrequest = 1'b0; #1;
        chk("fstall_rel_state", 32'(state), 32'd1);
        chk("fstall_rel_stall", 32'(stall), 32'd0);
        @(negedge clk); mem_access = 1'b0; exec_len = 4'd0; #1;
        chk("fstall_dec_state", 32'(state), 32'd2);
        chk("fstall_cnt", stall_count, 32'd3);

        // exec_len 0 clamps to 1; 9 clamps to 5
        @(negedge clk); exec_len = 4'd9; #1;
        chk("len0_state", 32'(state), 32'd3);
        chk("len0_last", 32'(last_exec), 32'd1);
        chk("len0_commit", 32'(commit), 32'd1);
        @(negedge clk); #1;
        chk("len9_fetch", 32'(state), 32'd1);
        @(negedge clk); #1;
        chk("len9_decode", 32'(state), 32'd2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            chk("len9_state", 32'(state), 32'(2 + k));
            chk("len9_last", 32'(last_exec), (k == 5) ? 32'd1 : 32'd0);
            chk("len9_commit", 32'(commit), (k == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk); exec_len = 4'd2; #1;
        chk("len9_after", 32'(state), 32'd1);
        chk("len9_instr", instr_count, 32'd5);

        // Mul/div busy for 10 cycles at EXEC2; one cycle also has waitrequest
        @(negedge clk); #1;
        chk("dm_decode", 32'(state), 32'd2);
        @(negedge clk); div_mult_wait = 1'b1; div_mult_busy = 1'b1; #1;
        chk("dm_exec1_state", 32'(state), 32'd3);
        chk("dm_exec1_nostall", 32'(stall), 32'd0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            mem_access  = (j == 3);
            waitrequest = (j == 3);
            #1;
            chk("dm_hold_state", 32'(state), 32'd4);
            chk("dm_hold_stall", 32'(stall), 32'd1);
            chk("dm_hold_commit", 32'(commit), 32'd0);
        end
        @(negedge clk); mem_access = 1'b0; waitrequest = 1'b0; div_mult_busy = 1'b0; #1;
        chk("dm_commit_state", 32'(state), 32'd4);
        chk("dm_commit", 32'(commit), 32'd1);
        chk("dm_stallcnt", stall_count, 32'd13);
        @(negedge clk); div_mult_wait = 1'b0; #1;
        chk("dm_after", 32'(state), 32'd1);
        chk("dm_instr", instr_count, 32'd6);

        // Halt request, first deferred by a memory stall at commit
        @(negedge clk); #1;
        chk("h_decode", 32'(state), 32'd2);
        @(negedge clk); halt_req = 1'b1; #1;
        chk("h_exec1", 32'(state), 32'd3);
        chk("h_exec1_commit", 32'(commit), 32'd0);
        @(negedge clk); mem_access = 1'b1; waitrequest = 1'b1; #1;
        chk("h_stall_state", 32'(state), 32'd4);
        chk("h_stall", 32'(stall), 32'd1);
        chk("h_stall_commit", 32'(commit), 32'd0);
        @(negedge clk); waitrequest = 1'b0; #1;
        chk("h_commit_state", 32'(state), 32'd4);
        chk("h_commit", 32'(commit), 32'd1);
        chk("h_stallcnt", stall_count, 32'd14);
        @(negedge clk); mem_access = 1'b0; halt_req = 1'b0; #1;
        chk("h_state", 32'(state), 32'd0);
        chk("h_active", 32'(active), 32'd0);
        chk("h_instr", instr_count, 32'd7);
        chk("h_commit_off", 32'(commit), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_access    = 1'($urandom_range(0, 1));
            waitrequest   = 1'($urandom_range(0, 1));
            div_mult_busy = 1'($urandom_range(0, 1));
            div_mult_wait = 1'($urandom_range(0, 1));
            halt_req      = 1'($urandom_range(0, 1));
            exec_len      = 4'($urandom_range(0, 15));
            #1;
            chk("halt_state", 32'(state), 32'd0);
            chk("halt_stall", 32'(stall), 32'd0);
            chk("halt_commit", 32'(commit), 32'd0);
        end
        chk("halt_instr", instr_count, 32'd7);
        chk("halt_stallcnt", stall_count, 32'd14);

        // Reset out of HALT, then async reset mid-EXEC1 during a stall
        @(negedge clk);
        mem_access = 1'b0; waitrequest = 1'b0; div_mult_busy = 1'b0;
        div_mult_wait = 1'b0; halt_req = 1'b0; exec_len = 4'd2;
        reset = 1'b1;
        #1;
        chk("r2_state", 32'(state), 32'd1);
        chk("r2_active", 32'(active), 32'd1);
        chk("r2_instr", instr_count, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("r2_decode", 32'(state), 32'd2);
        @(negedge clk); mem_access = 1'b1; waitrequest = 1'b1; #1;
        chk("r2_exec1", 32'(state), 32'd3);
        chk("r2_stall", 32'(stall), 32'd1);
        @(negedge clk); #1;
        chk("r2_exec1_hold", 32'(state), 32'd3);
        chk("r2_stallcnt", stall_count, 32'd1);
        #2; reset = 1'b1; #1;
        chk("ar_state", 32'(state), 32'd1);
        chk("ar_stallcnt", stall_count, 32'd0);
        chk("ar_instr", instr_count, 32'd0);
        chk("ar_last", 32'(last_exec), 32'd0);
        chk("ar_commit", 32'(commit), 32'd0);
        @(negedge clk); mem_access = 1'b0; waitrequest = 1'b0; #1;
        chk("ar_held", 32'(state), 32'd1);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("ar_decode", 32'(state), 32'd2);
        @(negedge clk); #1;
        chk("ar_exec1", 32'(state), 32'd3);
        @(negedge clk); #1;
        chk("ar_exec2", 32'(state), 32'd4);
        chk("ar_commit2", 32'(commit), 32'd1);
        @(negedge clk); #1;
        chk("ar_fetch", 32'(state), 32'd1);
        chk("ar_instr1", instr_count, 32'd1);
        chk("ar_stallcnt0", stall_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
